// File: rtl/writeback_sequencer_if.sv
// Execute-to-writeback bus: per-instruction result operands in, register-file
// write port and upstream stall out.
interface writeback_sequencer_if;
  logic        valid_in;
  logic        RW;
  logic [4:0]  DA;
  logic [1:0]  MD;
  logic [31:0] F;
  logic [31:0] Data_out;
  logic [63:0] F_mul;
  logic        VxorN;
  logic        stall;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  modport master (
    output valid_in, RW, DA, MD, F, Data_out, F_mul, VxorN,
    input  stall, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  valid_in, RW, DA, MD, F, Data_out, F_mul, VxorN,
    output stall, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/writeback_sequencer.sv
// Writeback stage: selects the result word and writes it to the register file,
// splitting a 64-bit multiply result into two consecutive writes (DA, DA+1).
module writeback_sequencer #(
  parameter int ZERO_REG_PROTECT = 1
) (
  input logic                  clk,
  input logic                  rst,
  writeback_sequencer_if.slave bus
);

  typedef enum logic {IDLE, HI} state_t;

  localparam bit PROTECT = (ZERO_REG_PROTECT != 0);

  state_t      state;
  logic        wr_en_q;
  logic [4:0]  wr_addr_q;
  logic [31:0] wr_data_q;
  logic [4:0]  hold_addr;
  logic [31:0] hold_data;

  logic [31:0] sel_data;
  logic        accept_write;
  logic        protect_da;
  logic        protect_hold;

  always_comb begin
    sel_data = bus.F;
    unique case (bus.MD)
      2'b00:   sel_data = bus.F;
      2'b01:   sel_data = bus.Data_out;
      2'b10:   sel_data = {31'd0, bus.VxorN};
      default: sel_data = bus.F_mul[31:0];
    endcase
  end

  assign accept_write = bus.valid_in && bus.RW;
  assign protect_da   = PROTECT && (bus.DA == 5'd0);
  assign protect_hold = PROTECT && (hold_addr == 5'd0);

  // In HI the inputs are ignored; upstream holds them because stall is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 5'd0;
      wr_data_q <= 32'd0;
      hold_addr <= 5'd0;
      hold_data <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept_write) begin
            wr_en_q   <= !protect_da;
            wr_addr_q <= bus.DA;
            wr_data_q <= sel_data;
            if (bus.MD == 2'b11) begin
              hold_addr <= bus.DA + 5'd1;
              hold_data <= bus.F_mul[63:32];
              state     <= HI;
            end
          end else begin
            wr_en_q <= 1'b0;
          end
        end
        HI: begin
          wr_en_q   <= !protect_hold;
          wr_addr_q <= hold_addr;
          wr_data_q <= hold_data;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stall   = (state == HI);
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_writeback_sequencer.sv
// Scoreboard bench: the driver expands each instruction into its register
// writes and queues per-cycle expectations; a negedge monitor compares them.
module tb_writeback_sequencer;

  localparam int ZRP = 1;

  typedef struct {
    logic        stall;
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  exp_t        exp_q[$];
  wr_t         wq[$];
  logic [4:0]  m_addr = 5'd0;
  logic [31:0] m_data = 32'd0;

  writeback_sequencer_if bus ();

  writeback_sequencer #(.ZERO_REG_PROTECT(ZRP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, actual, expected);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] md, input logic [31:0] f,
                                       input logic [31:0] dout, input logic [63:0] fmul,
                                       input logic vx);
    case (md)
      2'b00:   return f;
      2'b01:   return dout;
      2'b10:   return {31'd0, vx};
      default: return fmul[31:0];
    endcase
  endfunction

  // Holds the instruction on the bus until the model says it was taken
  // (one extra edge while the high word of a multiply is still pending).
  task automatic applyStimulus(input logic v, input logic rw, input logic [4:0] da,
                               input logic [1:0] md, input logic [31:0] f,
                               input logic [31:0] dout, input logic [63:0] fmul,
                               input logic vx);
    bus.valid_in = v;
    bus.RW       = rw;
    bus.DA       = da;
    bus.MD       = md;
    bus.F        = f;
    bus.Data_out = dout;
    bus.F_mul    = fmul;
    bus.VxorN    = vx;
    for (int k = 0; k < 3; k++) begin
      logic       consumed;
      logic [4:0] hi_addr;
      exp_t       e;
      wr_t        w;
      consumed = (wq.size() == 0);
      if (consumed && v && rw) begin
        w.addr = da;
        w.data = pick(md, f, dout, fmul, vx);
        wq.push_back(w);
        if (md == 2'b11) begin
          hi_addr = da + 5'd1;
          w.addr  = hi_addr;
          w.data  = fmul[63:32];
          wq.push_back(w);
        end
      end
      e.en = 1'b0;
      if (wq.size() > 0) begin
        w      = wq.pop_front();
        e.en   = !((ZRP != 0) && (w.addr == 5'd0));
        m_addr = w.addr;
        m_data = w.data;
      end
      e.addr  = m_addr;
      e.data  = m_data;
      e.stall = (wq.size() != 0);
      @(posedge clk);
      #1;
      exp_q.push_back(e);
      #1;
      if (consumed) break;
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput("stall", {31'd0, bus.stall}, {31'd0, e.stall});
      checkOutput("wr_en", {31'd0, bus.wr_en}, {31'd0, e.en});
      checkOutput("wr_addr", {27'd0, bus.wr_addr}, {27'd0, e.addr});
      checkOutput("wr_data", bus.wr_data, e.data);
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_stall"}, {31'd0, bus.stall}, 32'd0);
    checkOutput({tag, "_wr_en"}, {31'd0, bus.wr_en}, 32'd0);
    checkOutput({tag, "_wr_addr"}, {27'd0, bus.wr_addr}, 32'd0);
    checkOutput({tag, "_wr_data"}, bus.wr_data, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.valid_in = 1'b0;
    bus.RW       = 1'b0;
    bus.DA       = 5'd0;
    bus.MD       = 2'b00;
    bus.F        = 32'd0;
    bus.Data_out = 32'd0;
    bus.F_mul    = 64'd0;
    bus.VxorN    = 1'b0;
    #1;
    checkResetOutputs("reset");
    #21 rst = 1'b1;

    applyStimulus(1, 1, 5'd5, 2'b00, 32'h12345678, 32'd0, 64'd0, 0);
    applyStimulus(1, 1, 5'd7, 2'b11, 32'd0, 32'd0, 64'hDEADBEEF_00C0FFEE, 0);
    applyStimulus(0, 0, 5'd0, 2'b00, 32'd0, 32'd0, 64'd0, 0);
    applyStimulus(1, 1, 5'd31, 2'b11, 32'd0, 32'd0, 64'h11112222_33334444, 0);
    applyStimulus(0, 0, 5'd0, 2'b00, 32'd0, 32'd0, 64'd0, 0);
    // Second instruction is presented during the stall cycle of the first.
    applyStimulus(1, 1, 5'd12, 2'b11, 32'd0, 32'd0, 64'h0BADF00D_CAFEBABE, 0);
    applyStimulus(1, 1, 5'd3, 2'b01, 32'd0, 32'hA5A5A5A5, 64'd0, 0);
    applyStimulus(1, 1, 5'd20, 2'b11, 32'd0, 32'd0, 64'h00000001_00000002, 0);
    applyStimulus(1, 1, 5'd22, 2'b11, 32'd0, 32'd0, 64'h00000003_00000004, 0);
    applyStimulus(1, 1, 5'd2, 2'b10, 32'd0, 32'd0, 64'd0, 1);
    applyStimulus(1, 0, 5'd2, 2'b10, 32'd0, 32'd0, 64'd0, 1);
    applyStimulus(1, 1, 5'd0, 2'b10, 32'd0, 32'd0, 64'd0, 1);
    applyStimulus(1, 0, 5'd4, 2'b11, 32'd0, 32'd0, 64'hFFFFFFFF_FFFFFFFF, 0);
    applyStimulus(0, 1, 5'd6, 2'b00, 32'h55555555, 32'd0, 64'd0, 0);

    applyStimulus(1, 1, 5'd9, 2'b11, 32'd0, 32'd0, 64'h99999999_88888888, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checkResetOutputs("midhi");
    wq.delete();
    exp_q.delete();
    m_addr       = 5'd0;
    m_data       = 32'd0;
    bus.valid_in = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    repeat (3) applyStimulus(0, 0, 5'd0, 2'b00, 32'd0, 32'd0, 64'd0, 0);

    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(3) != 0, $urandom_range(3) != 0,
                    5'($urandom_range(31)), 2'($urandom_range(3)), $urandom, $urandom,
                    {$urandom, $urandom}, 1'($urandom_range(1)));
    end

    repeat (3) applyStimulus(0, 0, 5'd0, 2'b00, 32'd0, 32'd0, 64'd0, 0);
    @(negedge clk);
    #1;
    checkOutput("drain", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_sequencer.md
WRITEBACK_SEQUENCER -- requirements
Module: writeback_sequencer

Interface
REQ-001 Parameter: ZERO_REG_PROTECT, default 1, nonzero suppresses every register-file write addressed to R0.
REQ-002 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 Port rst, input, 1, reset, asynchronous and active-low.
REQ-004 Port valid_in, input, 1, execute-stage result valid this cycle.
REQ-005 Port RW, input, 1, register write requested by the instruction.
REQ-006 Port DA, input, 5, destination register address.
REQ-007 Port MD, input, 2, result select: 00 F, 01 Data_out, 10 VxorN zero-extended, 11 F_mul as two-word result.
REQ-008 Port F, input, 32, ALU result.
REQ-009 Port Data_out, input, 32, data-memory read result.
REQ-010 Port F_mul, input, 64, multiply result; [31:0] low word, [63:32] high word.
REQ-011 Port VxorN, input, 1, set-less-than flag.
REQ-012 Port stall, output, 1, holds upstream pipeline registers while high.
REQ-013 Port wr_en, output, 1, register-file write enable.
REQ-014 Port wr_addr, output, 5, register-file write address.
REQ-015 Port wr_data, output, 32, register-file write data.

Function
REQ-016 Two states: IDLE and HI; stall SHALL equal (state == HI), registered, no combinational path from inputs.
REQ-017 Inputs are accepted only at a rising edge with state IDLE; all inputs are ignored in HI.
REQ-018 wr_en, wr_addr, wr_data SHALL be registered; latency from accepted input to write = 1 cycle.
REQ-019 Accepted with valid_in=1, RW=1: wr_en<=1, wr_addr<=DA, wr_data<=value selected by MD (MD=11 selects F_mul[31:0]).
REQ-020 Accepted with valid_in=0 or RW=0: wr_en<=0; wr_addr and wr_data hold previous values; state stays IDLE.
REQ-021 Accepted with valid_in=1, RW=1, MD=11: F_mul[63:32] and DA+1 are captured into a hold register and state goes to HI.
REQ-022 MD=11 with RW=0: no write, no HI entry, no stall.
REQ-023 In HI, next edge: wr_en<=1, wr_addr<=DA+1, wr_data<=held high word; state returns to IDLE.
REQ-024 DA=31 with MD=11: DA+1 wraps to 0; the HI cycle still occurs and stall still asserts for one cycle; the high write obeys REQ-025.
REQ-025 When ZERO_REG_PROTECT is nonzero, any write whose address is 0 SHALL drive wr_en<=0 (address and data still updated).
REQ-026 Stall length for a two-word result is exactly one cycle; back-to-back MD=11 instructions each produce one stall cycle.
REQ-027 The instruction presented during a stall cycle SHALL be accepted at the first edge after stall deasserts, with no loss or duplication.

Reset
REQ-028 rst=0 asynchronously forces: state IDLE, stall 0, wr_en 0, wr_addr 0, wr_data 0, hold register 0.
REQ-029 Reset asserted in HI discards the pending high-word write; no write issues after rst rises until a new accepted input.
REQ-030 First accepted input is sampled at the first rising edge with rst=1.

Verification
REQ-031 MD=00, F=0x12345678, DA=5, RW=1, valid_in=1 -> next cycle wr_en=1, wr_addr=5, wr_data=0x12345678, stall=0.
REQ-032 MD=11, F_mul=0xDEADBEEF_00C0FFEE, DA=7 -> cycle+1: addr 7, data 0x00C0FFEE, stall=1; cycle+2: addr 8, data 0xDEADBEEF, stall=0.
REQ-033 MD=11, DA=31, protect on -> cycle+1: write R31 low word; cycle+2: wr_en=0, wr_addr=0, stall=1 during cycle+1; then stall=0.
REQ-034 During the stall cycle drive MD=01, Data_out=0xA5A5A5A5, DA=3 held -> no write in HI; written to R3 one cycle after stall drops, exactly once.
REQ-035 MD=10, VxorN=1, DA=2 -> wr_data=0x00000001; repeat with RW=0 -> wr_en=0; DA=0 with RW=1 -> wr_en=0.
REQ-036 Pulse rst=0 mid-HI after MD=11 DA=9 -> outputs zero immediately, no write to R10 after reset release.
